// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// One partial product is added per clock through a single WIDTH-bit ripple-carry row,
// so a WIDTH x WIDTH product takes WIDTH RUN cycles after the accepted start.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    operation request, honoured only while idle
//   a, b     multiplicand / multiplier, captured on the accepted start edge
//   busy     high while an operation is in progress
//   done     one-cycle pulse when product becomes valid
//   product  full 2*WIDTH-bit unsigned result, held until the next done or reset
module shift_add_multiplier #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [WIDTH-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               done_q;
   logic [2*WIDTH-1:0] product_q;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               carry;
   logic [2*WIDTH-1:0] shifted;
   logic               last;

   // Ripple-carry add of the current partial product into the upper accumulator half.
   always_comb begin
      logic c;
      addend = mplier_q[0] ? mcand_q : '0;
      sum    = '0;
      c      = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         sum[i] = acc_q[i] ^ addend[i] ^ c;
         c      = (acc_q[i] & addend[i]) | (c & (acc_q[i] ^ addend[i]));
      end
      carry = c;
   end

   // {carry, sum, mplier} >> 1; the dropped top bit is always zero, the carry lands in acc.
   assign shifted = {carry, sum, mplier_q[WIDTH-1:1]};
   assign last    = (cnt_q == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last)  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      busy    = (state_q == StRun);
      done    = done_q;
      product = product_q;
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  mcand_q  <= a;
                  mplier_q <= b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end
            end
            StRun: begin
               acc_q    <= shifted[2*WIDTH-1:WIDTH];
               mplier_q <= shifted[WIDTH-1:0];
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last) begin
                  product_q <= shifted;
                  done_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
